// File: rtl/bloom_filter_pkg.sv
// Shared constants, serializer FSM states and beat-count helper
// for the Bloom filter search pipeline.
package bloom_filter_pkg;

    localparam int BYTE_W         = 8;
    localparam int MIN_STR_SIZE   = 4;
    localparam int MAX_STR_SIZE   = 16;
    localparam int AMM_CSR_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int str_beats(input int len, input int symbols);
        return (len + symbols - 1) / symbols;
    endfunction

endpackage

// File: rtl/suspect_str_serializer_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after
// the pointer wins, wrapping at the top index.
module rr_arbiter #(
    parameter int REQ_CNT = 4,
    parameter int IDX_W   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
    input  logic [REQ_CNT-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [REQ_CNT-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    // Scan all requesters starting at the pointer, keep the first hit.
    always_comb begin
        int   w_idx;
        logic w_found;
        grant_o     = '0;
        grant_idx_o = '0;
        w_idx       = 0;
        w_found     = 1'b0;
        for (int i = 0; i < REQ_CNT; i++) begin
            w_idx = int'(rr_ptr_i) + i;
            if (w_idx >= REQ_CNT) begin
                w_idx = w_idx - REQ_CNT;
            end
            if (!w_found && req_i[IDX_W'(w_idx)]) begin
                w_found                = 1'b1;
                grant_o[IDX_W'(w_idx)] = 1'b1;
                grant_idx_o            = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/suspect_str_serializer.sv
// Picks one suspect string per packet (round-robin) and streams it
// out as an Avalon-ST packet, counting packets sent.
module suspect_str_serializer #(
    parameter int BYTE_W             = bloom_filter_pkg::BYTE_W,
    parameter int ENGINES            = 8,
    parameter int MIN_STR_SIZE       = bloom_filter_pkg::MIN_STR_SIZE,
    parameter int MAX_STR_SIZE       = bloom_filter_pkg::MAX_STR_SIZE,
    parameter int AST_SOURCE_SYMBOLS = 8,
    parameter int AST_SOURCE_ORDER   = 1,
    parameter int CNT_W              = bloom_filter_pkg::AMM_CSR_DATA_W,
    parameter int AST_SOURCE_EMPTY_W = (AST_SOURCE_SYMBOLS == 1) ? 1 :
                                       $clog2(AST_SOURCE_SYMBOLS)
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic [ENGINES-1:0][MAX_STR_SIZE:MIN_STR_SIZE]
                 [MAX_STR_SIZE-1:0][BYTE_W-1:0] suspect_strings_data_i,
    input  logic [ENGINES-1:0][MAX_STR_SIZE:MIN_STR_SIZE]
                 suspect_strings_valid_i,
    output logic [ENGINES-1:0][MAX_STR_SIZE:MIN_STR_SIZE]
                 suspect_strings_ready_o,
    output logic [AST_SOURCE_SYMBOLS-1:0][BYTE_W-1:0] ast_source_data_o,
    input  logic ast_source_ready_i,
    output logic ast_source_valid_o,
    output logic [AST_SOURCE_EMPTY_W-1:0] ast_source_empty_o,
    output logic ast_source_startofpacket_o,
    output logic ast_source_endofpacket_o,
    output logic [CNT_W-1:0] strings_cnt_o,
    input  logic strings_cnt_clean_stb_i
);

    import bloom_filter_pkg::*;

    localparam int S         = AST_SOURCE_SYMBOLS;
    localparam int NUM_LEN   = MAX_STR_SIZE - MIN_STR_SIZE + 1;
    localparam int REQ_CNT   = ENGINES * NUM_LEN;
    localparam int IDX_W     = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int LEN_W     = $clog2(MAX_STR_SIZE + 1);
    localparam int POS_W     = $clog2(MAX_STR_SIZE);
    localparam int SYM_W     = (S > 1) ? $clog2(S) : 1;
    localparam int MAX_BEATS = str_beats(MAX_STR_SIZE, S);
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic [REQ_CNT-1:0]                         w_req;
    logic [REQ_CNT-1:0]                         w_grant;
    logic [IDX_W-1:0]                           w_grant_idx;
    logic                                       w_any_req;
    logic [REQ_CNT-1:0][MAX_STR_SIZE-1:0][BYTE_W-1:0] w_data_flat;
    logic [LEN_W-1:0]                           w_grant_len;
    logic [IDX_W-1:0]                           w_ptr_nxt;
    logic                                       w_take;
    logic                                       w_accept;
    logic                                       w_last;
    logic [BEAT_W-1:0]                          w_last_beat;
    ser_state_t                                 w_state_nxt;

    ser_state_t                                 r_state;
    logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]        r_window;
    logic [LEN_W-1:0]                           r_len;
    logic [BEAT_W-1:0]                          r_beat;
    logic [IDX_W-1:0]                           r_rr_ptr;
    logic [CNT_W-1:0]                           r_cnt;

    assign w_req       = suspect_strings_valid_i;
    assign w_data_flat = suspect_strings_data_i;
    assign w_any_req   = |w_req;

    rr_arbiter #(
        .REQ_CNT (REQ_CNT),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (w_req),
        .rr_ptr_i    (r_rr_ptr),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx)
    );

    assign w_grant_len = LEN_W'(MIN_STR_SIZE + int'(w_grant_idx) % NUM_LEN);
    assign w_ptr_nxt   = IDX_W'((int'(w_grant_idx) + 1) % REQ_CNT);
    assign w_take      = (r_state == IDLE) && w_any_req;
    assign w_accept    = (r_state == SEND) && ast_source_ready_i;
    assign w_last_beat = BEAT_W'(str_beats(int'(r_len), S) - 1);
    assign w_last      = (r_beat == w_last_beat);

    assign suspect_strings_ready_o = w_take ? w_grant : '0;
    assign strings_cnt_o           = r_cnt;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: grant moves to SEND, accepted eop returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_any_req) w_state_nxt = SEND;
            SEND: if (w_accept && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the granted window and walk the beat index.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_window <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_rr_ptr <= '0;
        end else if (w_take) begin
            r_window <= w_data_flat[w_grant_idx];
            r_len    <= w_grant_len;
            r_beat   <= '0;
            r_rr_ptr <= w_ptr_nxt;
        end else if (w_accept && !w_last) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    // Saturating packet counter; clean strobe overrides increment.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_cnt <= '0;
        end else if (strings_cnt_clean_stb_i) begin
            r_cnt <= '0;
        end else if (w_accept && w_last && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Beat formatting: slice the window, zero bytes past the length.
    always_comb begin
        int w_pos;
        w_pos                      = 0;
        ast_source_data_o          = '0;
        ast_source_valid_o         = 1'b0;
        ast_source_startofpacket_o = 1'b0;
        ast_source_endofpacket_o   = 1'b0;
        ast_source_empty_o         = '0;
        if (r_state == SEND) begin
            ast_source_valid_o         = 1'b1;
            ast_source_startofpacket_o = (r_beat == '0);
            ast_source_endofpacket_o   = w_last;
            if (w_last) begin
                ast_source_empty_o = AST_SOURCE_EMPTY_W'(
                    (int'(w_last_beat) + 1) * S - int'(r_len));
            end
            for (int s = 0; s < S; s++) begin
                w_pos = int'(r_beat) * S + s;
                if ((w_pos < int'(r_len)) && (w_pos < MAX_STR_SIZE)) begin
                    if (AST_SOURCE_ORDER == 1) begin
                        ast_source_data_o[SYM_W'(S - 1 - s)] =
                            r_window[POS_W'(w_pos)];
                    end else begin
                        ast_source_data_o[SYM_W'(s)] =
                            r_window[POS_W'(w_pos)];
                    end
                end
            end
        end
    end

endmodule
